// File: rtl/i2c_master_v2.sv
// i2c_master_v2 -- single-master I2C controller, one 7-bit-addressed read or
// write burst of 1..2^CNT_W bytes per start request.
//
// Each bus bit is four quarter-periods Q0..Q3 of DIV clk each:
//   Q0,Q1 SCL low (SDA changes at Q0 entry), Q2,Q3 SCL released,
//   SDA sampled on the Q2->Q3 boundary.
//
// Optional build macro: I2C_CLK_STRETCH_EN
//   defined   : while SCL is released the divider waits for SCL to read high,
//               so a slave may stretch any bit, START or STOP.
//   undefined : SCL is never read back; timing comes purely from the divider.
//
// Ports
//   clk, rst          system clock (rising edge), async active-high reset
//   start             1-clk request; ignored while busy
//   addr, read_nwrite slave address and direction, latched on start accept
//   byte_count        burst length minus one, latched on start accept
//   data_i, data_i_valid  write byte stream; data_req pulses per byte wanted
//   data_o, new_data  last read byte and its 1-clk update strobe
//   busy              start accept through end of STOP
//   ack_err           slave NACK seen; sticky until next accepted start
//   SCL, SDA          open-drain bus pins (drive 0 or Z)

module i2c_master_v2 #(
  parameter int DIV   = 100,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [6:0]       addr,
  input  logic             read_nwrite,
  input  logic [CNT_W-1:0] byte_count,
  input  logic [7:0]       data_i,
  input  logic             data_i_valid,
  output logic             data_req,
  output logic [7:0]       data_o,
  output logic             new_data,
  output logic             busy,
  output logic             ack_err,
  inout  wire              SCL,
  inout  wire              SDA
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WR, S_WACK, S_RD, S_MACK, S_STOP
  } state_t;

  state_t           state, next_state;
  logic [DW-1:0]    div_cnt;
  logic [1:0]       q;
  logic [2:0]       bit_idx;
  logic [7:0]       tx_sr;
  logic [7:0]       rx_sr;
  logic             rnw_q;
  logic [CNT_W-1:0] remaining;
  logic             have_data;
  logic             ack_smp;
  logic             rd_done;

  logic scl_low, sda_low;
  logic stall, stretch, hold, qtick;
  logic accept, enter_wr;
  logic sda_in;

  assign SCL    = scl_low ? 1'b0 : 1'bz;
  assign SDA    = sda_low ? 1'b0 : 1'bz;
  assign sda_in = SDA;

  assign busy   = (state != S_IDLE);
  assign accept = (state == S_IDLE) && start;

  // Write byte not yet in hand: keep SCL low (we are in Q0 of bit 7) and
  // freeze the divider until the source supplies it.
  assign stall  = (state == S_WR) && !have_data && !data_i_valid;

`ifdef I2C_CLK_STRETCH_EN
  // SCL readback is asynchronous to clk, so resynchronise before use.
  logic [1:0] scl_sync;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) scl_sync <= 2'b11;
    else     scl_sync <= {scl_sync[0], SCL};
  end
  assign stretch = busy && !scl_low && !scl_sync[1];
`else
  assign stretch = 1'b0;
`endif

  assign hold  = stall || stretch;
  assign qtick = busy && !hold && (div_cnt == DW'(DIV - 1));

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // ---------------------------------------------------------------------
  // Next state and pin decode
  // ---------------------------------------------------------------------
  always_comb begin
    next_state = state;
    scl_low    = 1'b0;
    sda_low    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_START;
      end
      S_START: begin
        // SDA falls while SCL is still high; two quarters of hold time.
        sda_low = 1'b1;
        if (qtick && q == 2'd1) next_state = S_ADDR;
      end
      S_ADDR: begin
        scl_low = !q[1];
        sda_low = !tx_sr[7];
        if (qtick && q == 2'd3 && bit_idx == 3'd0) next_state = S_AACK;
      end
      S_AACK: begin
        scl_low = !q[1];
        if (qtick && q == 2'd3)
          next_state = ack_smp ? S_STOP : (rnw_q ? S_RD : S_WR);
      end
      S_WR: begin
        scl_low = !q[1];
        sda_low = !tx_sr[7];
        if (qtick && q == 2'd3 && bit_idx == 3'd0) next_state = S_WACK;
      end
      S_WACK: begin
        scl_low = !q[1];
        if (qtick && q == 2'd3)
          next_state = (ack_smp || remaining == '0) ? S_STOP : S_WR;
      end
      S_RD: begin
        scl_low = !q[1];
        if (qtick && q == 2'd3 && bit_idx == 3'd0) next_state = S_MACK;
      end
      S_MACK: begin
        // ACK while more bytes are wanted, NACK (released) on the last one.
        scl_low = !q[1];
        sda_low = (remaining != '0);
        if (qtick && q == 2'd3)
          next_state = (remaining != '0) ? S_RD : S_STOP;
      end
      S_STOP: begin
        // q0: both low, q1: SCL up, q2: SDA up (the STOP edge).
        scl_low = (q == 2'd0);
        sda_low = (q != 2'd2);
        if (qtick && q == 2'd2) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign enter_wr = (next_state == S_WR) && (state != S_WR);

  // ---------------------------------------------------------------------
  // Divider, bit counters, shifters, handshakes
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      q         <= 2'd0;
      bit_idx   <= 3'd7;
      tx_sr     <= 8'h00;
      rx_sr     <= 8'h00;
      rnw_q     <= 1'b0;
      remaining <= '0;
      have_data <= 1'b0;
      ack_smp   <= 1'b0;
      rd_done   <= 1'b0;
      data_req  <= 1'b0;
      new_data  <= 1'b0;
      data_o    <= 8'h00;
      ack_err   <= 1'b0;
    end else begin
      data_req <= enter_wr;
      rd_done  <= 1'b0;
      // Read byte is published one clk after its 8th sample.
      new_data <= rd_done;
      if (rd_done) data_o <= rx_sr;

      if (accept) begin
        tx_sr     <= {addr, read_nwrite};
        rnw_q     <= read_nwrite;
        remaining <= byte_count;
        ack_err   <= 1'b0;
        div_cnt   <= '0;
        q         <= 2'd0;
        bit_idx   <= 3'd7;
      end else if (busy && !hold) begin
        div_cnt <= qtick ? '0 : div_cnt + DW'(1);
      end

      // First valid byte at/after data_req is taken; later ones ignored.
      if (enter_wr)
        have_data <= 1'b0;
      else if (state == S_WR && !have_data && data_i_valid) begin
        tx_sr     <= data_i;
        have_data <= 1'b1;
      end

      if (qtick) begin
        if (next_state != state) begin
          q       <= 2'd0;
          bit_idx <= 3'd7;
        end else begin
          q <= q + 2'd1;
          if (q == 2'd3) bit_idx <= bit_idx - 3'd1;
        end

        if (q == 2'd2) begin
          case (state)
            S_AACK, S_WACK: ack_smp <= sda_in;
            S_RD: begin
              rx_sr   <= {rx_sr[6:0], sda_in};
              rd_done <= (bit_idx == 3'd0);
            end
            default: ;
          endcase
        end

        if (q == 2'd3) begin
          case (state)
            S_ADDR, S_WR: tx_sr <= {tx_sr[6:0], 1'b0};
            S_AACK: if (ack_smp) ack_err <= 1'b1;
            S_WACK: begin
              if (ack_smp)                ack_err   <= 1'b1;
              else if (remaining != '0)   remaining <= remaining - CNT_W'(1);
            end
            S_MACK: if (remaining != '0) remaining <= remaining - CNT_W'(1);
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_v2.sv
module tb_i2c_master_v2;
  localparam int DIV   = 4;
  localparam int CNT_W = 4;
  localparam logic [6:0] SL_ADDR = 7'h5A;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [6:0]       addr;
  logic             read_nwrite;
  logic [CNT_W-1:0] byte_count;
  logic [7:0]       data_i;
  logic             data_i_valid;
  logic             data_req;
  logic [7:0]       data_o;
  logic             new_data;
  logic             busy;
  logic             ack_err;
  wire              scl;
  wire              sda;

  logic sl_sda_low, sl_scl_low;
  pullup (scl);
  pullup (sda);
  assign sda = sl_sda_low ? 1'b0 : 1'bz;
  assign scl = sl_scl_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_master_v2 #(.DIV(DIV), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .read_nwrite(read_nwrite),
    .byte_count(byte_count), .data_i(data_i), .data_i_valid(data_i_valid),
    .data_req(data_req), .data_o(data_o), .new_data(new_data), .busy(busy),
    .ack_err(ack_err), .SCL(scl), .SDA(sda)
  );

  int n_chk = 0, n_err = 0;
  int n_start = 0, n_stop = 0, n_req = 0, n_rise = 0;
  int stall_at = 0, stall_done = 0, ack_low = 0;

  logic [7:0] exp_bus[$];
  logic [7:0] exp_rd[$];
  logic       exp_mack[$];
  logic [7:0] wr_src[$];
  logic [7:0] sl_rd_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural slave (address SL_ADDR) ----------------
  typedef enum int {M_IDLE, M_ADDR, M_RX, M_TX} sl_mode_t;
  sl_mode_t   mode;
  int         pos, low_cnt, str_cnt;
  logic       pscl, psda, cs, cd;
  logic [7:0] sl_rx, sl_tx;

  task automatic load_tx();
    sl_tx = (sl_rd_q.size() != 0) ? sl_rd_q.pop_front() : 8'hFF;
  endtask

  task automatic bus_byte(input logic [7:0] b);
    if (exp_bus.size() == 0) chk("bus_unexpected", exp_bus.size(), 1);
    else chk("bus_byte", b, exp_bus.pop_front());
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sl_sda_low = 1'b0; sl_scl_low = 1'b0; mode = M_IDLE;
      pscl = 1'b1; psda = 1'b1; pos = 0; low_cnt = 0; str_cnt = 0;
    end else begin
      cs = scl; cd = sda;
      if (cs == 1'b0) low_cnt++;
      if (pscl && cs && psda && !cd) begin
        n_start++; mode = M_ADDR; pos = 0; sl_rx = 8'h00; sl_sda_low = 1'b0;
      end else if (pscl && cs && !psda && cd) begin
        n_stop++; mode = M_IDLE; sl_sda_low = 1'b0;
      end else if (!pscl && cs) begin
        n_rise++;
        if (pos < 8) sl_rx = {sl_rx[6:0], cd};
        else begin
          case (mode)
            M_ADDR: begin
              ack_low = low_cnt;
              bus_byte(sl_rx);
              if (sl_rx[7:1] != SL_ADDR) mode = M_IDLE;
              else if (sl_rx[0]) begin mode = M_TX; load_tx(); end
              else mode = M_RX;
            end
            M_RX: bus_byte(sl_rx);
            M_TX: begin
              if (exp_mack.size() == 0) chk("mack_unexpected", exp_mack.size(), 1);
              else chk("master_ack", cd, exp_mack.pop_front());
              if (cd) mode = M_IDLE; else load_tx();
            end
            default: ;
          endcase
        end
        pos = (pos == 8) ? 0 : pos + 1;
        low_cnt = 0;
      end else if (pscl && !cs) begin
        sl_sda_low = 1'b0;
        if (mode == M_TX && pos < 8) sl_sda_low = !sl_tx[7-pos];
        else if (mode == M_RX && pos == 8) sl_sda_low = 1'b1;
        else if (mode == M_ADDR && pos == 8 && sl_rx[7:1] == SL_ADDR) begin
          sl_sda_low = 1'b1;
`ifdef I2C_CLK_STRETCH_EN
          sl_scl_low = 1'b1; str_cnt = 10;
`endif
        end
      end
      pscl = cs; psda = cd;
      if (str_cnt > 0) begin
        str_cnt--;
        if (str_cnt == 0) sl_scl_low = 1'b0;
      end
    end
  end

  // ---------------- write-data source ----------------
  initial begin
    int r0;
    data_i = 8'h00; data_i_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && data_req) begin
        n_req++;
        if (n_req == stall_at) begin
          r0 = n_rise;
          repeat (20) @(negedge clk);
          chk("stall_scl_low", scl, 0);
          chk("stall_no_rise", n_rise - r0, 0);
          stall_done = 1;
        end
        if (wr_src.size() == 0) begin
          chk("wr_src_empty", wr_src.size(), 1);
          data_i = 8'h00;
        end else data_i = wr_src.pop_front();
        data_i_valid = 1'b1;
        @(negedge clk);
        data_i_valid = 1'b0;
      end
    end
  end

  // ---------------- read-data checker ----------------
  always @(negedge clk) begin
    if (!rst && new_data) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", new_data, 0);
      else chk("rd_data", data_o, exp_rd.pop_front());
    end
  end

  task automatic go(input logic [6:0] a, input logic rnw, input logic [CNT_W-1:0] bc);
    addr = a; read_nwrite = rnw; byte_count = bc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    #1500000;
    $display("FAIL global_timeout busy=%0d", busy);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int s0, p0, r0, n;
    rst = 1'b1; start = 1'b0; addr = 7'h00; read_nwrite = 1'b0; byte_count = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_data_req", data_req, 0);
    chk("rst_new_data", new_data, 0);
    chk("rst_data_o", data_o, 8'h00);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    rst = 1'b0;
    @(negedge clk);

    // T1: write 2 bytes, plus an ignored start while busy
    exp_bus.push_back(8'hB4); exp_bus.push_back(8'hA5); exp_bus.push_back(8'h3C);
    wr_src.push_back(8'hA5); wr_src.push_back(8'h3C);
    s0 = n_start; p0 = n_stop; r0 = n_req;
    go(SL_ADDR, 1'b0, 4'd1);
    chk("t1_busy_on", busy, 1);
    repeat (40) @(negedge clk);
    go(7'h21, 1'b1, 4'd0);
    wait_idle(3000);
    chk("t1_ack_err", ack_err, 0);
    chk("t1_data_req", n_req - r0, 2);
    chk("t1_starts", n_start - s0, 1);
    chk("t1_stops", n_stop - p0, 1);
`ifdef I2C_CLK_STRETCH_EN
    chk("t1_ack_stretched", ack_low >= 10, 1);
`else
    chk("t1_ack_scl_low", ack_low, 2*DIV);
`endif

    // T2: read 3 bytes
    exp_bus.push_back(8'hB5);
    sl_rd_q.push_back(8'h11); sl_rd_q.push_back(8'h22); sl_rd_q.push_back(8'h33);
    exp_rd.push_back(8'h11); exp_rd.push_back(8'h22); exp_rd.push_back(8'h33);
    exp_mack.push_back(1'b0); exp_mack.push_back(1'b0); exp_mack.push_back(1'b1);
    p0 = n_stop;
    go(SL_ADDR, 1'b1, 4'd2);
    wait_idle(3000);
    chk("t2_rd_left", exp_rd.size(), 0);
    chk("t2_mack_left", exp_mack.size(), 0);
    chk("t2_ack_err", ack_err, 0);
    chk("t2_stop", n_stop - p0, 1);

    // T3: absent slave
    exp_bus.push_back(8'h42);
    p0 = n_stop; r0 = n_req;
    go(7'h21, 1'b0, 4'd0);
    wait_idle(3000);
    chk("t3_ack_err", ack_err, 1);
    chk("t3_data_req", n_req - r0, 0);
    chk("t3_stop", n_stop - p0, 1);

    // T4: write 3 bytes, source stalls 20 clk on the 2nd byte
    exp_bus.push_back(8'hB4);
    exp_bus.push_back(8'h77); exp_bus.push_back(8'h88); exp_bus.push_back(8'h99);
    wr_src.push_back(8'h77); wr_src.push_back(8'h88); wr_src.push_back(8'h99);
    r0 = n_req;
    stall_at = n_req + 2;
    go(SL_ADDR, 1'b0, 4'd2);
    chk("t4_ack_err_clr", ack_err, 0);
    wait_idle(4000);
    chk("t4_data_req", n_req - r0, 3);
    chk("t4_stall_seen", stall_done, 1);
    chk("t4_bus_left", exp_bus.size(), 0);

    // T5: maximum burst, 16 read bytes
    exp_bus.push_back(8'hB5);
    for (int i = 0; i < 16; i++) begin
      sl_rd_q.push_back(8'(i * 37 + 5));
      exp_rd.push_back(8'(i * 37 + 5));
      exp_mack.push_back(i == 15);
    end
    go(SL_ADDR, 1'b1, 4'hF);
    wait_idle(8000);
    chk("t5_rd_left", exp_rd.size(), 0);
    chk("t5_mack_left", exp_mack.size(), 0);

    // T6: minimum burst, single write byte
    exp_bus.push_back(8'hB4); exp_bus.push_back(8'hC3);
    wr_src.push_back(8'hC3);
    r0 = n_req;
    go(SL_ADDR, 1'b0, 4'd0);
    wait_idle(3000);
    chk("t6_data_req", n_req - r0, 1);
    chk("t6_bus_left", exp_bus.size(), 0);

    // T7: reset in the middle of read bit 3
    exp_bus.push_back(8'hB5);
    sl_rd_q.push_back(8'h0F); sl_rd_q.push_back(8'h55);
    go(SL_ADDR, 1'b1, 4'd1);
    n = 0;
    while (!(mode == M_TX && pos == 4) && n < 3000) begin @(negedge clk); n++; end
    chk("t7_reach_bit4", (mode == M_TX && pos == 4), 1);
    n = 0;
    while (scl && n < 200) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_scl", scl, 1);
    chk("t7_sda", sda, 1);
    chk("t7_data_o", data_o, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    sl_rd_q.delete();
    repeat (20) @(negedge clk);
    chk("t7_stay_idle", busy, 0);

    chk("end_bus_left", exp_bus.size(), 0);
    chk("end_rd_left", exp_rd.size(), 0);
    chk("end_wr_left", wr_src.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
